// File: rtl/masked_aes_pkg.sv
// rtl/masked_aes_pkg.sv - shared types and constants for the masked ShiftRows buffer
// Contents: byte_t, bank_state_e (EMPTY/FILLING/FULL/DRAINING), NBYTES,
// SHIFTROWS_IDX (output position j -> stored byte index).
package masked_aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_e;

  localparam int NBYTES = 16;

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  // Entry j holds r+4((c+r) mod 4) for j=r+4c; entry 0 is the least significant nibble.
  localparam logic [NBYTES-1:0][3:0] SHIFTROWS_IDX = {
    4'd11, 4'd6, 4'd1, 4'd12, 4'd7, 4'd2, 4'd13, 4'd8,
    4'd3, 4'd14, 4'd9, 4'd4, 4'd15, 4'd10, 4'd5, 4'd0
  };

endpackage

// File: rtl/masked_shiftrows_buf_if.sv
// rtl/masked_shiftrows_buf_if.sv - byte stream interface of the masked ShiftRows buffer
// Input side: m0, m1, in_data, in_valid, in_ready.
// Output side: out_data, out_valid, out_ready, out_m0, out_m1, out_last.
// master = upstream/downstream environment, slave = the buffer.
import masked_aes_pkg::*;

interface masked_shiftrows_buf_if;
  logic  m0;
  logic  m1;
  byte_t in_data;
  logic  in_valid;
  logic  in_ready;
  byte_t out_data;
  logic  out_valid;
  logic  out_ready;
  logic  out_m0;
  logic  out_m1;
  logic  out_last;

  modport master (
    output m0, m1, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_m0, out_m1, out_last
  );

  modport slave (
    input  m0, m1, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_m0, out_m1, out_last
  );
endinterface

// File: rtl/masked_state_bank.sv
// rtl/masked_state_bank.sv - one 16-byte bank with mask register and fill/drain state
// Ports: clk, rst_n (async, active-low); wr_en/wptr/wr_data/wr_m0/wr_m1 write side;
// rd_en/rptr read side; rd_data (ShiftRows-ordered byte), m0/m1 (block mask),
// can_write (EMPTY or FILLING), can_read (FULL or DRAINING).
import masked_aes_pkg::*;

module masked_state_bank #(
  parameter bit ZERO_ON_DRAIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wptr,
  input  byte_t      wr_data,
  input  logic       wr_m0,
  input  logic       wr_m1,
  input  logic       rd_en,
  input  logic [3:0] rptr,
  output byte_t      rd_data,
  output logic       m0,
  output logic       m1,
  output logic       can_write,
  output logic       can_read
);

  bank_state_e state, state_next;
  byte_t       mem [NBYTES];
  logic [3:0]  rd_idx;

  assign rd_idx  = SHIFTROWS_IDX[rptr];
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:    if (wr_en) state_next = (wptr == LAST_IDX) ? FULL : FILLING;
      FILLING:  if (wr_en && wptr == LAST_IDX) state_next = FULL;
      FULL:     if (rd_en) state_next = (rptr == LAST_IDX) ? EMPTY : DRAINING;
      DRAINING: if (rd_en && rptr == LAST_IDX) state_next = EMPTY;
      default:  state_next = EMPTY;
    endcase
  end

  always_comb begin
    can_write = (state == EMPTY) || (state == FILLING);
    can_read  = (state == FULL) || (state == DRAINING);
  end

  // A bank is never written and read in the same cycle (write needs EMPTY/FILLING,
  // read needs FULL/DRAINING), so the write and the drain clear cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBYTES; i++) mem[i] <= '0;
      m0 <= 1'b0;
      m1 <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= wr_data;
        if (wptr == 4'd0) begin
          m0 <= wr_m0;
          m1 <= wr_m1;
        end
      end
      if (ZERO_ON_DRAIN && rd_en) mem[rd_idx] <= '0;
    end
  end

endmodule

// File: rtl/masked_shiftrows_buf.sv
// rtl/masked_shiftrows_buf.sv - ping-pong buffer applying ShiftRows to a masked byte stream
// Ports: clk, rst_n (async, active-low), bus (slave modport): column-major masked
// bytes with block mask bits in, ShiftRows-ordered bytes with mask metadata and
// out_last out. Data is only moved, never combined with the mask bits.
import masked_aes_pkg::*;

module masked_shiftrows_buf #(
  parameter bit ZERO_ON_DRAIN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  masked_shiftrows_buf_if.slave       bus
);

  logic       wsel, rsel;
  logic [3:0] wptr, rptr;
  logic [1:0] can_write, can_read, bank_m0, bank_m1;
  byte_t      bank_rd_data [2];
  logic       in_ready, out_valid, in_fire, out_fire;

  // rst_n gating keeps in_ready low for the whole reset interval.
  assign in_ready  = rst_n & can_write[wsel];
  assign out_valid = can_read[rsel];
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    masked_state_bank #(
      .ZERO_ON_DRAIN(ZERO_ON_DRAIN)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (in_fire && (wsel == 1'(b))),
      .wptr      (wptr),
      .wr_data   (bus.in_data),
      .wr_m0     (bus.m0),
      .wr_m1     (bus.m1),
      .rd_en     (out_fire && (rsel == 1'(b))),
      .rptr      (rptr),
      .rd_data   (bank_rd_data[b]),
      .m0        (bank_m0[b]),
      .m1        (bank_m1[b]),
      .can_write (can_write[b]),
      .can_read  (can_read[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      wsel <= 1'b0;
    end else if (in_fire) begin
      wptr <= wptr + 4'd1;
      if (wptr == LAST_IDX) wsel <= ~wsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      rsel <= 1'b0;
    end else if (out_fire) begin
      rptr <= rptr + 4'd1;
      if (rptr == LAST_IDX) rsel <= ~rsel;
    end
  end

  // Outputs are forced to zero when nothing is draining so no stale byte is visible.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_data  = out_valid ? bank_rd_data[rsel] : '0;
    bus.out_m0    = out_valid & bank_m0[rsel];
    bus.out_m1    = out_valid & bank_m1[rsel];
    bus.out_last  = out_valid & (rptr == LAST_IDX);
  end

endmodule

// File: tb/tb_masked_shiftrows_buf.sv
// tb/tb_masked_shiftrows_buf.sv - scoreboard bench for masked_shiftrows_buf
module tb_masked_shiftrows_buf;

  typedef struct packed {
    logic [7:0] d;
    logic       m0;
    logic       m1;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  masked_shiftrows_buf_if ifc();

  masked_shiftrows_buf #(.ZERO_ON_DRAIN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  logic [7:0] blk [16];
  logic       cur_m0, cur_m1;
  int         wcount, rcount, full_blocks;
  int         n_checks, n_fail;
  int         n_in, cyc, blk_done_cyc, ov_rise_cyc, gap_cnt;
  logic       prev_ov;

  logic       drv_valid, drv_ordy, drv_m0, drv_m1, seq_mode;
  logic [7:0] drv_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_block();
    exp_t e;
    int   r, c;
    for (int j = 0; j < 16; j++) begin
      r = j % 4;
      c = j / 4;
      e.d    = blk[r + 4 * ((c + r) % 4)];
      e.m0   = cur_m0;
      e.m1   = cur_m1;
      e.last = (j == 15);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    logic in_fire, out_fire;
    exp_t e;
    @(negedge clk);
    ifc.in_valid  = drv_valid;
    ifc.in_data   = drv_data;
    ifc.m0        = drv_m0;
    ifc.m1        = drv_m1;
    ifc.out_ready = drv_ordy;
    #1;
    cyc++;
    check_eq("in_ready", ifc.in_ready, (rst_n && full_blocks < 2));
    check_eq("out_valid", ifc.out_valid, (full_blocks > 0));
    if (rst_n && drv_valid && !ifc.in_ready) gap_cnt++;
    if (ifc.out_valid && !prev_ov) ov_rise_cyc = cyc;
    prev_ov = ifc.out_valid;
    if (ifc.out_valid) begin
      check_eq("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb[0];
        check_eq("out_data", ifc.out_data, e.d);
        check_eq("out_m0", ifc.out_m0, e.m0);
        check_eq("out_m1", ifc.out_m1, e.m1);
        check_eq("out_last", ifc.out_last, e.last);
      end
    end else begin
      check_eq("idle_data", ifc.out_data, 0);
      check_eq("idle_m0", ifc.out_m0, 0);
      check_eq("idle_m1", ifc.out_m1, 0);
      check_eq("idle_last", ifc.out_last, 0);
    end
    in_fire  = ifc.in_valid && ifc.in_ready;
    out_fire = ifc.out_valid && ifc.out_ready;
    if (out_fire && sb.size() > 0) begin
      sb.delete(0);
      rcount++;
      if (rcount == 16) begin
        rcount = 0;
        full_blocks--;
      end
    end
    if (in_fire) begin
      if (wcount == 0) begin
        cur_m0 = ifc.m0;
        cur_m1 = ifc.m1;
      end
      blk[wcount] = ifc.in_data;
      wcount++;
      n_in++;
      if (wcount == 16) begin
        push_block();
        full_blocks++;
        wcount = 0;
        blk_done_cyc = cyc;
      end
      if (seq_mode) drv_data = drv_data + 8'd1;
      else begin
        drv_data = 8'($urandom);
        drv_m0   = 1'($urandom);
        drv_m1   = 1'($urandom);
      end
    end
  endtask

  task automatic run(input int nbytes, input int pv, input int pr, input int budget);
    int target, n;
    target = n_in + nbytes;
    n = 0;
    while (n_in < target && n < budget) begin
      drv_valid = ($urandom_range(99) < pv);
      drv_ordy  = ($urandom_range(99) < pr);
      step();
      n++;
    end
    check_eq("send_done", (n_in >= target), 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    drv_valid = 1'b0;
    drv_ordy  = 1'b1;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_done", sb.size(), 0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    wcount = 0;
    rcount = 0;
    full_blocks = 0;
    prev_ov = 1'b0;
    drv_valid = 1'b1;
    drv_ordy  = 1'b1;
    repeat (hold) step();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_in = 0; cyc = 0; gap_cnt = 0;
    wcount = 0; rcount = 0; full_blocks = 0; prev_ov = 1'b0;
    blk_done_cyc = 0; ov_rise_cyc = 0; cur_m0 = 1'b0; cur_m1 = 1'b0;
    seq_mode = 1'b0; drv_valid = 1'b0; drv_ordy = 1'b0;
    drv_data = 8'h00; drv_m0 = 1'b0; drv_m1 = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_data = 8'h00; ifc.m0 = 1'b0; ifc.m1 = 1'b0; ifc.out_ready = 1'b0;

    // Reset state, with in_valid asserted throughout
    do_reset(3);

    // Bytes 0x00..0x0F, m0=1 m1=0, out_ready=1
    seq_mode = 1'b1;
    drv_data = 8'h00;
    drv_m0 = 1'b1;
    drv_m1 = 1'b0;
    run(16, 100, 100, 100);
    drain(64);
    check_eq("first_valid_latency", ov_rise_cyc - blk_done_cyc, 1);
    seq_mode = 1'b0;

    // Three back-to-back blocks, no input stalls expected
    gap_cnt = 0;
    run(48, 100, 100, 200);
    check_eq("stream_gaps", gap_cnt, 0);
    drain(64);

    // Backpressure: 32 bytes fill both banks, then input must stall
    run(32, 100, 0, 200);
    drv_valid = 1'b1;
    drv_ordy  = 1'b0;
    repeat (3) step();
    check_eq("stall_in_ready", ifc.in_ready, 0);
    run(16, 100, 100, 200);
    drain(64);

    // Reset after 7 bytes of a block, then a fresh block
    run(7, 100, 100, 50);
    do_reset(2);
    run(16, 100, 100, 100);
    drain(64);

    // 1000 blocks with random stalls on both sides
    run(16000, 70, 70, 90000);
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
